// File: rtl/sword_sseg_serial.sv
// rtl/sword_sseg_serial.sv - serial shift-register driver for the 8-digit seven-segment display
// Optional leading-zero blanking is enabled by defining SSEG_ZERO_BLANK_EN.
module sword_sseg_serial #(
  parameter string SIM = "FALSE"
) (
  input  logic        clk,
  input  logic [31:0] data,
  output logic        ss_dout,
  output logic        ss_clk,
  output logic        ss_en,
  input  logic        rst_n
);

  localparam int         HALF      = (SIM == "TRUE") ? 1 : 25;
  localparam logic [4:0] HALF_LAST = 5'(HALF - 1);

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH
  } state_t;

  function automatic logic [63:0] encode(input logic [31:0] v);
    logic [63:0] f;
    logic [3:0]  nib;
`ifdef SSEG_ZERO_BLANK_EN
    logic        lead;
    lead = 1'b1;
`endif
    f = '0;
    for (int i = 7; i >= 0; i--) begin
      nib = v[i*4 +: 4];
`ifdef SSEG_ZERO_BLANK_EN
      // Digit 0 always shows, so a zero value still renders one "0".
      if (lead && nib == 4'h0 && i != 0) begin
        f[i*8 +: 8] = 8'hFF;
      end else begin
        lead        = 1'b0;
        f[i*8 +: 8] = GLYPH[nib];
      end
`else
      f[i*8 +: 8] = GLYPH[nib];
`endif
    end
    return f;
  endfunction

  state_t      state, state_n;
  logic [63:0] sreg, sreg_n;
  logic [4:0]  half_cnt, half_n;
  logic [5:0]  bit_cnt, bit_n;
  logic        latch_phase, latch_phase_n;
  logic        dout_n, sclk_n, en_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      sreg        <= '0;
      half_cnt    <= '0;
      bit_cnt     <= '0;
      latch_phase <= 1'b0;
      ss_dout     <= 1'b0;
      ss_clk      <= 1'b0;
      ss_en       <= 1'b0;
    end else begin
      state       <= state_n;
      sreg        <= sreg_n;
      half_cnt    <= half_n;
      bit_cnt     <= bit_n;
      latch_phase <= latch_phase_n;
      ss_dout     <= dout_n;
      ss_clk      <= sclk_n;
      ss_en       <= en_n;
    end
  end

  always_comb begin
    state_n       = state;
    sreg_n        = sreg;
    half_n        = half_cnt;
    bit_n         = bit_cnt;
    latch_phase_n = latch_phase;
    dout_n        = ss_dout;
    sclk_n        = ss_clk;
    en_n          = ss_en;

    case (state)
      ST_LOAD: begin
        sreg_n        = encode(data);
        dout_n        = sreg_n[63];
        bit_n         = '0;
        half_n        = '0;
        latch_phase_n = 1'b0;
        sclk_n        = 1'b0;
        en_n          = 1'b0;
        state_n       = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (half_cnt == HALF_LAST) begin
          half_n = '0;
          if (!ss_clk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            // Falling edge: either present the next bit or, after bit 0, latch.
            if (bit_cnt == 6'd63) begin
              bit_n         = '0;
              en_n          = 1'b1;
              latch_phase_n = 1'b0;
              state_n       = ST_LATCH;
            end else begin
              bit_n  = bit_cnt + 6'd1;
              sreg_n = {sreg[62:0], 1'b0};
              dout_n = sreg[62];
            end
          end
        end else begin
          half_n = half_cnt + 5'd1;
        end
      end

      ST_LATCH: begin
        // Two half-periods counted with a phase bit so the 5-bit counter suffices.
        if (half_cnt == HALF_LAST) begin
          half_n = '0;
          if (latch_phase) begin
            en_n    = 1'b0;
            state_n = ST_LOAD;
          end else begin
            latch_phase_n = 1'b1;
          end
        end else begin
          half_n = half_cnt + 5'd1;
        end
      end

      default: begin
        state_n = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_sword_sseg_serial.sv
// tb/tb_sword_sseg_serial.sv - self-checking bench for sword_sseg_serial
module tb_sword_sseg_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] data = 32'h0;
  logic        ss_dout, ss_clk, ss_en;
  logic        s_dout, s_clk, s_en;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sword_sseg_serial #(.SIM("TRUE")) dut (
    .clk(clk), .data(data), .ss_dout(ss_dout), .ss_clk(ss_clk), .ss_en(ss_en), .rst_n(rst_n)
  );

  sword_sseg_serial #(.SIM("FALSE")) dut_slow (
    .clk(clk), .data(data), .ss_dout(s_dout), .ss_clk(s_clk), .ss_en(s_en), .rst_n(rst_n)
  );

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [63:0] ref_frame(input logic [31:0] v);
    logic [63:0] f;
    logic [7:0]  g;
    int          nib;
`ifdef SSEG_ZERO_BLANK_EN
    bit          blank;
    blank = 1'b1;
`endif
    f = 64'h0;
    for (int d = 7; d >= 0; d--) begin
      nib = int'((v >> (4 * d)) & 32'hF);
      g   = seg_tab[nib];
`ifdef SSEG_ZERO_BLANK_EN
      if (nib != 0 || d == 0) blank = 1'b0;
      if (blank) g = 8'hFF;
`endif
      f = (f << 8) | 64'(g);
    end
    return f;
  endfunction

  // Receiver model for the fast instance: shift on ss_clk rise, capture on ss_en rise.
  logic [63:0] rx = 64'h0, last_frame = 64'h0;
  int   rises = 0, rises_at_en = 0, en_count = 0, cyc = 0, last_en_cyc = 0, period = 0;
  logic p_clk = 1'b0, p_en = 1'b0;
  bit   overlap = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if ((ss_clk && ss_en) || (s_clk && s_en)) overlap = 1'b1;
    if (!rst_n) begin
      rises = 0;
    end else begin
      if (ss_clk && !p_clk) begin
        rx = {rx[62:0], ss_dout};
        rises++;
      end
      if (ss_en && !p_en) begin
        last_frame  = rx;
        rises_at_en = rises;
        rises       = 0;
        period      = cyc - last_en_cyc;
        last_en_cyc = cyc;
        en_count++;
      end
    end
    p_clk = ss_clk;
    p_en  = ss_en;
  end

  // Phase-length and frame monitor for the full-speed instance.
  logic [63:0] s_rx = 64'h0, s_frame = 64'h0;
  int   s_run = 0, s_en_run = 0, s_hi_len = 0, s_lo_len = 0, s_en_len = 0;
  int   s_en_cnt = 0, s_last_rise = 0, s_period = 0;
  bit   s_lo_dirty = 1'b1, s_rise_valid = 1'b0;
  logic sp_clk = 1'b0, sp_en = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_run        = 0;
      s_en_run     = 0;
      s_lo_dirty   = 1'b1;
      s_rise_valid = 1'b0;
      sp_clk       = 1'b0;
      sp_en        = 1'b0;
    end else begin
      if (s_clk != sp_clk) begin
        if (sp_clk) s_hi_len = s_run;
        else if (!s_lo_dirty) s_lo_len = s_run;
        if (s_clk) s_rx = {s_rx[62:0], s_dout};
        s_run      = 1;
        s_lo_dirty = 1'b0;
      end else begin
        s_run++;
      end
      if (s_en) s_lo_dirty = 1'b1;
      if (s_en != sp_en) begin
        if (sp_en) begin
          s_en_len = s_en_run;
        end else begin
          if (s_rise_valid) s_period = cyc - s_last_rise;
          s_last_rise  = cyc;
          s_rise_valid = 1'b1;
          s_frame      = s_rx;
          s_en_cnt++;
        end
        s_en_run = 1;
      end else begin
        s_en_run++;
      end
      sp_clk = s_clk;
      sp_en  = s_en;
    end
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_en(input int n);
    for (int j = 0; j < n; j++) begin
      int start;
      start = en_count;
      for (int k = 0; k < 1000 && en_count == start; k++) begin
        @(negedge clk);
        #1;
      end
      chk_int("en_event", en_count - start, 1);
    end
  endtask

  task automatic wait_en_low();
    for (int k = 0; k < 200 && ss_en; k++) @(negedge clk);
    chk_int("en_fall", int'(ss_en), 0);
  endtask

  task automatic frame_check(input string tag, input logic [31:0] v);
    wait_en(2);
    chk64(tag, last_frame, ref_frame(v));
    chk_int("ss_clk_rises", rises_at_en, 64);
    chk_int("frame_period", period, 131);
  endtask

  initial begin
    logic [31:0] v;
    int e0, s0;

    repeat (3) @(negedge clk);
    chk_int("reset_fast", int'({ss_dout, ss_clk, ss_en}), 0);
    chk_int("reset_slow", int'({s_dout, s_clk, s_en}), 0);
    rst_n = 1'b1;

    data = 32'h01234567;
    frame_check("frame_01234567", data);
`ifndef SSEG_ZERO_BLANK_EN
    chk64("lit_01234567", last_frame, 64'hC0F9A4B0_999282F8);
`endif

    data = 32'h89ABCDEF;
    frame_check("frame_89abcdef", data);
    chk64("lit_89abcdef", last_frame, 64'h80908883_C6A1868E);

    // Data change in the middle of SHIFT must not affect the frame in flight.
    data = 32'h01234567;
    wait_en(2);
    wait_en_low();
    repeat (20) @(negedge clk);
    data = 32'hFFFFFFFF;
    wait_en(1);
    chk64("midshift_old", last_frame, ref_frame(32'h01234567));
    wait_en(1);
    chk64("midshift_new", last_frame, 64'h8E8E8E8E_8E8E8E8E);

    data = 32'h00000405;
    frame_check("frame_00000405", data);
`ifdef SSEG_ZERO_BLANK_EN
    chk64("lit_00000405", last_frame, 64'hFFFFFFFF_FF99C092);
`else
    chk64("lit_00000405", last_frame, 64'hC0C0C0C0_C099C092);
`endif
    data = 32'h00000000;
    frame_check("frame_zero", data);
`ifdef SSEG_ZERO_BLANK_EN
    chk64("lit_zero", last_frame, 64'hFFFFFFFF_FFFFFFC0);
`else
    chk64("lit_zero", last_frame, 64'hC0C0C0C0_C0C0C0C0);
`endif

    for (int r = 0; r < 6; r++) begin
      v = $urandom >> $urandom_range(0, 31);
      data = v;
      frame_check("frame_random", v);
    end

    // Asynchronous reset while ss_clk is high in the middle of a frame.
    wait_en(1);
    wait_en_low();
    repeat (30) @(negedge clk);
    for (int k = 0; k < 4 && !ss_clk; k++) @(negedge clk);
    chk_int("pre_reset_sclk", int'(ss_clk), 1);
    e0 = en_count;
    #2 rst_n = 1'b0;
    #1;
    chk_int("async_reset_out", int'({ss_dout, ss_clk, ss_en}), 0);
    chk_int("async_reset_slow", int'({s_dout, s_clk, s_en}), 0);
    repeat (4) @(negedge clk);
    chk_int("reset_hold_out", int'({ss_dout, ss_clk, ss_en}), 0);
    data = $urandom;
    rst_n = 1'b1;
    wait_en(1);
    chk_int("no_partial_latch", en_count, e0 + 1);
    chk64("post_reset_frame", last_frame, ref_frame(data));
    chk_int("post_reset_rises", rises_at_en, 64);

    // Full-speed instance: phase lengths, latch pulse and frame period.
    s0 = s_en_cnt;
    for (int k = 0; k < 9000 && s_en_cnt < s0 + 2; k++) @(negedge clk);
    chk_int("slow_en_events", s_en_cnt - s0, 2);
    repeat (60) @(negedge clk);
    chk_int("slow_high_phase", s_hi_len, 25);
    chk_int("slow_low_phase", s_lo_len, 25);
    chk_int("slow_en_pulse", s_en_len, 50);
    chk_int("slow_period", s_period, 3251);
    chk64("slow_frame", s_frame, ref_frame(data));

    chk_int("en_clk_overlap", int'(overlap), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
